// File: rtl/uart_tx_fifo_if.sv
// Register bus between a host and uart_tx_fifo: one write or read strobe per cycle,
// byte-addressed, with registered read data.
interface uart_tx_fifo_if;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        w_en;
  logic        r_en;
  logic [63:0] rdata;

  modport master (output addr, wdata, w_en, r_en, input rdata);
  modport slave  (input addr, wdata, w_en, r_en, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, a programmable baud divisor
// and a byte mirror (out/out_en) for a simulation console.
module uart_tx_fifo #(
  parameter logic [7:0]       BASE_TOP   = 8'h81,
  parameter int unsigned      FIFO_DEPTH = 16,
  parameter int unsigned      DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RST    = DIV_W'(433)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fifo_if.slave     bus,
  output logic              tx,
  output logic [7:0]        out,
  output logic              out_en
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             tx_en, ovf;
  logic [DIV_W-1:0] div, div_lat, cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [63:0]      rd_mux;

  logic       sel, wr_ctrl, wr_data, wr_status, wr_div, clr;
  logic       full, empty, pop, push, ovf_evt;
  logic [7:0] off;
  logic       unused_bits;

  assign sel       = (bus.addr[31:24] == BASE_TOP);
  assign off       = bus.addr[7:0];
  assign wr_ctrl   = bus.w_en && sel && (off == 8'h00);
  assign wr_data   = bus.w_en && sel && (off == 8'h04);
  assign wr_status = bus.w_en && sel && (off == 8'h08);
  assign wr_div    = bus.w_en && sel && (off == 8'h0C);
  assign clr       = wr_ctrl && bus.wdata[1];

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && tx_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push    = wr_data && !clr && (!full || pop);
  assign ovf_evt = wr_data && !clr && full && !pop;

  assign unused_bits = ^{bus.addr[63:32], bus.addr[23:8], bus.wdata[63:8]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en <= 1'b0;
      ovf   <= 1'b0;
      div   <= DIV_RST;
    end else begin
      if (wr_ctrl) tx_en <= bus.wdata[0];
      if (wr_div)  div   <= bus.wdata[DIV_W-1:0];
      if (ovf_evt)                       ovf <= 1'b1;
      else if (wr_status && bus.wdata[3]) ovf <= 1'b0;
    end
  end

  // tx is registered: each state transition also loads the level for the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      out     <= '0;
      out_en  <= 1'b0;
      cnt     <= '0;
      div_lat <= DIV_RST;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      out_en <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            out     <= mem[rd_ptr];
            out_en  <= 1'b1;
            div_lat <= div;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == div_lat) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (cnt == div_lat) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (cnt == div_lat) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel) begin
      case (off)
        8'h00: rd_mux[0] = tx_en;
        8'h08: begin
          rd_mux[0]    = empty;
          rd_mux[1]    = full;
          rd_mux[2]    = (state != IDLE);
          rd_mux[3]    = ovf;
          rd_mux[15:8] = 8'(count);
        end
        8'h0C: rd_mux[DIV_W-1:0] = div;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            bus.rdata <= '0;
    else if (bus.r_en)  bus.rdata <= rd_mux;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: register vector table, directed line-timing
// sequences, and randomized traffic checked against a serial-line reference model.
module tb_uart_tx_fifo;

  localparam logic [7:0] BASE = 8'h81;
  localparam logic [7:0] CTRL = 8'h00, DATA = 8'h04, STAT = 8'h08, DIVR = 8'h0C;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic [7:0] out;
  logic       out_en;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.BASE_TOP(8'h81), .FIFO_DEPTH(16), .DIV_W(16), .DIV_RST(16'd433)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .out(out), .out_en(out_en)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] top, input logic [7:0] off, input logic [63:0] d);
    bus.addr  = {32'h0, top, 16'h0, off};
    bus.wdata = d;
    bus.w_en  = 1'b1;
    tick();
    bus.w_en  = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] top, input logic [7:0] off, output logic [63:0] d);
    bus.addr = {32'h0, top, 16'h0, off};
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    d = bus.rdata;
  endtask

  task automatic wr(input logic [7:0] off, input logic [63:0] d);
    bus_write(BASE, off, d);
  endtask

  task automatic rd_check(input string name, input logic [7:0] off, input logic [63:0] exp);
    logic [63:0] d;
    bus_read(BASE, off, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_out_en(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (out_en === 1'b1) seen = 1'b1;
      else tick();
    end
    check(name, 64'(seen), 64'd1);
  endtask

  // Ideal 8N1 line level c cycles after a frame starts, bit time div+1.
  function automatic logic line_bit(input logic [7:0] b, input int div, input int c);
    int k;
    k = c / (div + 1);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  logic cap_tx [0:127];
  logic cap_en [0:127];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      cap_tx[i] = tx;
      cap_en[i] = out_en;
    end
  endtask

  // Console monitor and serial line decoder (decoder active only when mon_en is set).
  logic [7:0] outq [$];
  logic [7:0] rxq  [$];
  bit         mon_en = 1'b0;
  int         rdiv = 0;
  int         frame_err = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (out_en === 1'b1) outq.push_back(out);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && tx === 1'b0) begin
      int t;
      logic [7:0] b;
      t = rdiv + 1;
      b = '0;
      for (int c = 0; c < 10 * t; c++) begin
        int k;
        if (c > 0) begin @(posedge clk); #1; end
        k = c / t;
        if (k == 0) begin
          if (tx !== 1'b0) frame_err++;
        end else if (k <= 8) begin
          if (c % t == 0) b[k-1] = tx;
          else if (tx !== b[k-1]) frame_err++;
        end else if (tx !== 1'b1) begin
          frame_err++;
        end
      end
      rxq.push_back(b);
    end
  end

  typedef struct {
    int          kind;   // 0 write, 1 read and compare, 2 compare held rdata
    logic [7:0]  top;
    logic [7:0]  off;
    logic [63:0] wd;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vt [$];

  task automatic add(input int k, input logic [7:0] top, input logic [7:0] off,
                     input logic [63:0] wd, input logic [63:0] exp, input string nm);
    vec_t v;
    v.kind = k; v.top = top; v.off = off; v.wd = wd; v.exp = exp; v.name = nm;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    logic [63:0] d;
    logic [7:0] b3 [3];
    logic [7:0] mq [$];
    bit movf;

    bus.addr = '0; bus.wdata = '0; bus.w_en = 1'b0; bus.r_en = 1'b0;
    do_reset();
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_out", 64'(out), 64'd0);
    check("rst_out_en", 64'(out_en), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);

    // Register access vectors
    add(1, BASE, CTRL, 0, 64'h0, "ctrl_rst");
    add(1, BASE, STAT, 0, 64'h1, "status_rst");
    add(1, BASE, DIVR, 0, 64'd433, "div_rst");
    add(1, BASE, DATA, 0, 64'h0, "data_reads0");
    add(0, BASE, DIVR, 64'd3, 0, "");
    add(1, BASE, DIVR, 0, 64'd3, "div_rw");
    add(0, 8'h80, DIVR, 64'd9, 0, "");
    add(1, BASE, DIVR, 0, 64'd3, "unsel_write_ignored");
    add(1, 8'h80, DIVR, 0, 64'h0, "unsel_read_zero");
    add(0, BASE, DIVR, '1, 0, "");
    add(1, BASE, DIVR, 0, 64'hFFFF, "div_zero_ext");
    add(0, BASE, 8'h10, 64'h5, 0, "");
    add(1, BASE, 8'h10, 0, 64'h0, "bad_offset");
    add(1, BASE, DIVR, 0, 64'hFFFF, "div_before_hold");
    add(0, BASE, DIVR, 64'd3, 0, "");
    add(2, BASE, DIVR, 0, 64'hFFFF, "rdata_hold");
    add(1, BASE, DIVR, 0, 64'd3, "div_after_hold");
    add(0, BASE, CTRL, 64'h1, 0, "");
    add(1, BASE, CTRL, 0, 64'h1, "ctrl_tx_en");
    add(0, BASE, CTRL, 64'h3, 0, "");
    add(1, BASE, CTRL, 0, 64'h1, "ctrl_clear_reads0");
    add(0, BASE, CTRL, 64'h0, 0, "");
    add(1, BASE, STAT, 0, 64'h1, "status_still_empty");

    foreach (vt[i]) begin
      case (vt[i].kind)
        0: bus_write(vt[i].top, vt[i].off, vt[i].wd);
        1: begin bus_read(vt[i].top, vt[i].off, d); check(vt[i].name, d, vt[i].exp); end
        default: check(vt[i].name, bus.rdata, vt[i].exp);
      endcase
    end

    // Single frame, DIV=3, byte 0xA5
    do_reset();
    wr(DIVR, 3); wr(CTRL, 1); wr(DATA, 64'hA5);
    wait_out_en("a5_out_en_seen");
    check("a5_out", 64'(out), 64'hA5);
    capture(41);
    errs = 0;
    for (int i = 0; i < 41; i++) begin
      if (cap_tx[i] !== ((i < 40) ? line_bit(8'hA5, 3, i) : 1'b1)) errs++;
      if (i > 0 && cap_en[i] !== 1'b0) errs++;
    end
    check("a5_line", 64'(errs), 64'd0);
    rd_check("a5_not_busy", STAT, 64'h1);

    // Overflow: 17 writes into a 16-deep FIFO with tx disabled
    do_reset();
    for (int v = 0; v <= 16; v++) wr(DATA, 64'(v));
    rd_check("ovf_status", STAT, 64'h100A);
    wr(STAT, 64'h8);
    rd_check("ovf_cleared", STAT, 64'h1002);
    outq.delete();
    wr(DIVR, 0); wr(CTRL, 1);
    repeat (16 * 11 + 10) tick();
    check("ovf_drain_count", 64'(outq.size()), 64'd16);
    errs = 0;
    foreach (outq[i]) if (outq[i] !== 8'(i)) errs++;
    check("ovf_drain_order", 64'(errs), 64'd0);
    rd_check("ovf_drain_empty", STAT, 64'h1);

    // Three back-to-back frames at DIV=0
    do_reset();
    b3[0] = 8'h3C; b3[1] = 8'hC3; b3[2] = 8'h81;
    wr(DIVR, 0);
    for (int i = 0; i < 3; i++) wr(DATA, 64'(b3[i]));
    wr(CTRL, 1);
    wait_out_en("b2b_out_en_seen");
    capture(33);
    errs = 0;
    for (int i = 0; i < 33; i++) begin
      int f, c;
      f = i / 11; c = i % 11;
      if (cap_tx[i] !== ((c == 10) ? 1'b1 : line_bit(b3[f], 0, c))) errs++;
    end
    check("b2b_line", 64'(errs), 64'd0);
    errs = 0;
    for (int i = 0; i < 33; i++) if (cap_en[i] !== (i % 11 == 0)) errs++;
    check("b2b_out_en_spacing", 64'(errs), 64'd0);

    // DIV rewritten mid-frame takes effect on the next frame only
    do_reset();
    wr(DIVR, 1); wr(DATA, 64'h5A); wr(DATA, 64'h96); wr(CTRL, 1);
    wait_out_en("div_mid_out_en_seen");
    fork
      capture(101);
      begin repeat (6) tick(); wr(DIVR, 7); end
    join
    errs = 0;
    for (int i = 0; i < 101; i++) begin
      logic e;
      if (i < 20)       e = line_bit(8'h5A, 1, i);
      else if (i == 20) e = 1'b1;
      else              e = line_bit(8'h96, 7, i - 21);
      if (cap_tx[i] !== e) errs++;
    end
    check("div_mid_line", 64'(errs), 64'd0);
    check("div_mid_second_pop", 64'(cap_en[21]), 64'd1);

    // Push in the pop cycle while full
    do_reset();
    wr(DIVR, 0);
    for (int i = 0; i < 16; i++) wr(DATA, 64'(i));
    outq.delete();
    wr(CTRL, 1);
    wr(DATA, 64'hEE);
    rd_check("full_push_pop_status", STAT, 64'h1006);
    repeat (17 * 11 + 10) tick();
    check("full_push_pop_count", 64'(outq.size()), 64'd17);
    errs = 0;
    foreach (outq[i]) if (outq[i] !== ((i < 16) ? 8'(i) : 8'hEE)) errs++;
    check("full_push_pop_order", 64'(errs), 64'd0);

    // fifo_clear while a frame is in flight
    do_reset();
    wr(DIVR, 0); wr(CTRL, 1);
    outq.delete();
    wr(DATA, 64'h11); wr(DATA, 64'h22); wr(DATA, 64'h33);
    wr(CTRL, 64'h3);
    rd_check("clear_busy_status", STAT, 64'h5);
    repeat (15) tick();
    check("clear_one_frame", 64'(outq.size()), 64'd1);
    rd_check("clear_idle_status", STAT, 64'h1);

    // tx_en dropped mid-frame: frame completes, no further pop
    do_reset();
    wr(DIVR, 0); wr(DATA, 64'h44); wr(DATA, 64'h55);
    outq.delete();
    wr(CTRL, 1);
    wait_out_en("txen_off_out_en_seen");
    wr(CTRL, 0);
    repeat (20) tick();
    check("txen_off_one_frame", 64'(outq.size()), 64'd1);
    rd_check("txen_off_status", STAT, 64'h100);

    // Reset during DATA state
    do_reset();
    wr(DIVR, 3); wr(CTRL, 1); wr(DATA, 64'h00);
    wait_out_en("rst_mid_out_en_seen");
    repeat (10) tick();
    check("rst_mid_tx_low", 64'(tx), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_tx_high", 64'(tx), 64'd1);
    check("rst_mid_out", 64'(out), 64'd0);
    rd_check("rst_mid_status", STAT, 64'h1);
    rd_check("rst_mid_div", DIVR, 64'd433);
    rd_check("rst_mid_ctrl", CTRL, 64'h0);

    // Randomized traffic against the FIFO/line reference model
    do_reset();
    mon_en = 1'b1;
    movf = 1'b0;
    for (int r = 0; r < 8; r++) begin
      int n, bound;
      logic [63:0] es;
      rdiv = $urandom_range(0, 2);
      wr(DIVR, 64'(rdiv));
      mq.delete();
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        wr(DATA, 64'(b));
        if (mq.size() < 16) mq.push_back(b);
        else movf = 1'b1;
      end
      es = (64'(mq.size()) << 8) | (64'(movf) << 3) |
           (64'(mq.size() == 16) << 1) | 64'(mq.size() == 0);
      rd_check("rnd_status_queued", STAT, es);
      if ($urandom_range(0, 1) == 1) begin
        wr(STAT, 64'h8);
        movf = 1'b0;
      end
      rxq.delete();
      outq.delete();
      frame_err = 0;
      wr(CTRL, 1);
      bound = mq.size() * 11 * (rdiv + 1) + 40;
      for (int i = 0; i < bound && rxq.size() < mq.size(); i++) tick();
      repeat (3) tick();
      check("rnd_rx_count", 64'(rxq.size()), 64'(mq.size()));
      errs = 0;
      foreach (mq[i]) begin
        if (i >= rxq.size() || rxq[i] !== mq[i]) errs++;
        if (i >= outq.size() || outq[i] !== mq[i]) errs++;
      end
      check("rnd_bytes", 64'(errs), 64'd0);
      check("rnd_framing", 64'(frame_err), 64'd0);
      wr(CTRL, 0);
      rd_check("rnd_status_drained", STAT, (64'(movf) << 3) | 64'h1);
    end
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
